if_stage: RTL and testbench

//   Instruction-fetch stage; the producer of the instr word consumed by id_stage.

---
 rtl/if_stage.sv | 121 ++++++++++++
 tb/tb_if_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle synchronous
// instruction-memory reads, buffers returned words in a 2-entry FIFO and
// hands them to ID with a valid/ready handshake. Redirects flush everything.
module if_stage #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 10,
    parameter int RESET_PC  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 imem_en,
    output logic [ADDR_SIZE-1:0] imem_addr,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    input  logic                 id_ready,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr,
    output logic [ADDR_SIZE-1:0] pc
);

    localparam logic [ADDR_SIZE-1:0] RESET_ADDR = ADDR_SIZE'(RESET_PC);
    localparam logic [ADDR_SIZE-1:0] PC_STEP    = ADDR_SIZE'(4);
    localparam logic [WORD_SIZE-1:0] NOP_WORD   = WORD_SIZE'(32'h0000_0013);

    logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_SIZE-1:0] rd_pc_q, rd_pc_d;      // address of the read in flight
    logic                 inflight_q, inflight_d;
    logic [1:0]           occ_q, occ_d;

    // Entry 0 is always the head; entry 1 is only meaningful when occ_q == 2.
    logic [ADDR_SIZE-1:0] fifo_pc_q   [2];
    logic [ADDR_SIZE-1:0] fifo_pc_d   [2];
    logic [WORD_SIZE-1:0] fifo_word_q [2];
    logic [WORD_SIZE-1:0] fifo_word_d [2];

    logic       head_valid;
    logic       pop;
    logic [1:0] pending;
    logic [1:0] level;

    assign head_valid = (occ_q != 2'd0);
    assign pop        = head_valid & id_ready;

    // Slots that will still be claimed after this cycle's pop; a new read is
    // only issued when it is guaranteed somewhere to land.
    assign pending = occ_q + {1'b0, inflight_q} - {1'b0, pop};

    // Read strobe: suppressed in reset and on redirect, otherwise issue while room remains.
    always_comb begin
        imem_en = rst & ~redirect & (pending < 2'd2);
    end

    assign imem_addr   = fetch_pc_q;
    assign instr_valid = head_valid;
    assign instr       = head_valid ? fifo_word_q[0] : NOP_WORD;
    assign pc          = head_valid ? fifo_pc_q[0]   : '0;

    // Next-state: redirect flush, else pop-shift then push the returning word.
    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        rd_pc_d        = fetch_pc_q;
        inflight_d     = 1'b0;
        occ_d          = occ_q;
        level          = occ_q;
        fifo_pc_d[0]   = fifo_pc_q[0];
        fifo_pc_d[1]   = fifo_pc_q[1];
        fifo_word_d[0] = fifo_word_q[0];
        fifo_word_d[1] = fifo_word_q[1];
        if (redirect) begin
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            fetch_pc_d = {redirect_pc[ADDR_SIZE-1:2], 2'b00};
        end else begin
            if (pop) begin
                fifo_pc_d[0]   = fifo_pc_q[1];
                fifo_word_d[0] = fifo_word_q[1];
                level          = occ_q - 2'd1;
            end
            if (inflight_q) begin
                // level is 0 or 1 here: the issue rule always leaves a slot.
                fifo_pc_d[level[0]]   = rd_pc_q;
                fifo_word_d[level[0]] = imem_rdata;
            end
            occ_d      = level + {1'b0, inflight_q};
            inflight_d = imem_en;
            if (imem_en) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
        end
    end

    // Control state: PC, in-flight tracking and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_ADDR;
            rd_pc_q    <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_pc_q    <= rd_pc_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
        end
    end

    // FIFO storage, one register pair per entry.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                fifo_pc_q[gi]   <= '0;
                fifo_word_q[gi] <= '0;
            end else begin
                fifo_pc_q[gi]   <= fifo_pc_d[gi];
                fifo_word_q[gi] <= fifo_word_d[gi];
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle-exact vector table, random traffic against a
// stream-level reference model, and an asynchronous mid-stream reset.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_en;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        id_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [9:0]  pc;

    int n_cmp;
    int n_bad;
    int cyc;

    // Reference model: next pc ID must see, next address fetch must issue,
    // and cycles since the last restart (redirect or reset).
    logic [9:0] m_next;
    logic [9:0] m_issue;
    int         m_since;

    typedef struct {
        logic       rdy;
        logic       redir;
        logic [9:0] rpc;
        logic       e_valid;
        logic [9:0] e_pc;
        logic       e_en;
        logic [9:0] e_addr;
    } vec_t;

    vec_t tbl [21];

    if_stage #(.WORD_SIZE(32), .ADDR_SIZE(10), .RESET_PC(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: word at a is A000_0000 | a.
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= 32'hA000_0000 | {22'b0, imem_addr};
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %h, want %h", nm, cyc, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic d, input logic [9:0] rp,
                                input logic ev, input logic [9:0] ep,
                                input logic een, input logic [9:0] ea);
        vec_t v;
        v.rdy = r; v.redir = d; v.rpc = rp;
        v.e_valid = ev; v.e_pc = ep; v.e_en = een; v.e_addr = ea;
        return v;
    endfunction

    task automatic model_restart();
        m_next  = 10'h000;
        m_issue = 10'h000;
        m_since = 1;
    endtask

    // Drive one cycle's inputs, check against the model, update the model.
    task automatic step(input logic rdy, input logic redir, input logic [9:0] rpc);
        logic exp_v;
        id_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #1;
        exp_v = (m_since >= 3);
        chk("valid", 32'(instr_valid), 32'(exp_v));
        if (exp_v) begin
            chk("pc", 32'(pc), 32'(m_next));
            chk("instr", instr, 32'hA000_0000 | {22'b0, m_next});
        end else begin
            chk("pc_idle", 32'(pc), 32'h0);
            chk("instr_idle", instr, 32'h0000_0013);
        end
        chk("fetch_addr", 32'(imem_addr), 32'(m_issue));
        if (redir) chk("en_on_redirect", 32'(imem_en), 32'h0);
        if (exp_v && rdy)
            $display("cycle %0d: ID takes pc=%h instr=%h", cyc, pc, instr);
        if (exp_v && rdy) m_next = m_next + 10'd4;
        if (imem_en) m_issue = m_issue + 10'd4;
        if (redir) begin
            m_next  = {rpc[9:2], 2'b00};
            m_issue = {rpc[9:2], 2'b00};
            m_since = 0;
        end
        if (m_since < 3) m_since++;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        clk = 1'b0; rst = 1'b0;
        id_ready = 1'b0; redirect = 1'b0; redirect_pc = 10'h0;
        model_restart();

        // Startup, stall, full-FIFO redirect, redirect-with-pop, wrap.
        tbl[0]  = mk(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h000);
        tbl[1]  = mk(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h004);
        tbl[2]  = mk(1'b1, 1'b0, 10'h000, 1'b1, 10'h000, 1'b1, 10'h008);
        tbl[3]  = mk(1'b1, 1'b0, 10'h000, 1'b1, 10'h004, 1'b1, 10'h00C);
        tbl[4]  = mk(1'b0, 1'b0, 10'h000, 1'b1, 10'h008, 1'b0, 10'h010);
        tbl[5]  = mk(1'b0, 1'b0, 10'h000, 1'b1, 10'h008, 1'b0, 10'h010);
        tbl[6]  = mk(1'b0, 1'b0, 10'h000, 1'b1, 10'h008, 1'b0, 10'h010);
        tbl[7]  = mk(1'b1, 1'b0, 10'h000, 1'b1, 10'h008, 1'b1, 10'h010);
        tbl[8]  = mk(1'b1, 1'b0, 10'h000, 1'b1, 10'h00C, 1'b1, 10'h014);
        tbl[9]  = mk(1'b0, 1'b0, 10'h000, 1'b1, 10'h010, 1'b0, 10'h018);
        tbl[10] = mk(1'b0, 1'b1, 10'h1C2, 1'b1, 10'h010, 1'b0, 10'h018);
        tbl[11] = mk(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h1C0);
        tbl[12] = mk(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h1C4);
        tbl[13] = mk(1'b1, 1'b0, 10'h000, 1'b1, 10'h1C0, 1'b1, 10'h1C8);
        tbl[14] = mk(1'b1, 1'b1, 10'h3F9, 1'b1, 10'h1C4, 1'b0, 10'h1CC);
        tbl[15] = mk(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h3F8);
        tbl[16] = mk(1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h3FC);
        tbl[17] = mk(1'b1, 1'b0, 10'h000, 1'b1, 10'h3F8, 1'b1, 10'h000);
        tbl[18] = mk(1'b1, 1'b0, 10'h000, 1'b1, 10'h3FC, 1'b1, 10'h004);
        tbl[19] = mk(1'b1, 1'b0, 10'h000, 1'b1, 10'h000, 1'b1, 10'h008);
        tbl[20] = mk(1'b1, 1'b0, 10'h000, 1'b1, 10'h004, 1'b1, 10'h00C);

        // Reset state.
        repeat (3) @(negedge clk);
        id_ready = 1'b1;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_en", 32'(imem_en), 32'h0);
        chk("rst_addr", 32'(imem_addr), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Cycle-exact vector table.
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
            chk("tbl_valid", 32'(instr_valid), 32'(tbl[i].e_valid));
            chk("tbl_pc", 32'(pc), tbl[i].e_valid ? 32'(tbl[i].e_pc) : 32'h0);
            chk("tbl_instr", instr, tbl[i].e_valid ? (32'hA000_0000 | 32'(tbl[i].e_pc))
                                                   : 32'h0000_0013);
            chk("tbl_en", 32'(imem_en), 32'(tbl[i].e_en));
            chk("tbl_addr", 32'(imem_addr), 32'(tbl[i].e_addr));
            $display("vector %0d: rdy=%b redir=%b valid=%b pc=%h en=%b addr=%h",
                     i, tbl[i].rdy, tbl[i].redir, instr_valid, pc, imem_en, imem_addr);
            next_cycle();
        end

        // Random traffic against the stream model.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
                 10'($urandom));
            next_cycle();
        end

        // Asynchronous reset between clock edges.
        id_ready = 1'b1;
        redirect = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(instr_valid), 32'h0);
        chk("arst_instr", instr, 32'h0000_0013);
        chk("arst_pc", 32'(pc), 32'h0);
        chk("arst_en", 32'(imem_en), 32'h0);
        chk("arst_addr", 32'(imem_addr), 32'h0);
        $display("async reset applied mid-stream");
        repeat (2) next_cycle();
        rst = 1'b1;
        model_restart();
        step(1'b1, 1'b0, 10'h0);
        chk("restart_first_issue", 32'(imem_en), 32'h1);
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 10'h0);
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
